// File: rtl/id_ex_stage_p_pkg.sv
// Shared constants, control bundle and helpers for the ID/EX decode stage.
// Holds format, memory-size, write-back, opcode, ALU and FSM encodings.
package id_ex_stage_p_pkg;

   localparam logic [2:0] FT_R = 3'd0, FT_I = 3'd1, FT_S = 3'd2, FT_B = 3'd3,
                          FT_U = 3'd4, FT_J = 3'd5, FT_P = 3'd6;

   localparam logic [1:0] MEM_NONE = 2'b00, MEM_B = 2'b01, MEM_H = 2'b10, MEM_W = 2'b11;
   localparam logic [1:0] MTR_ALU = 2'b00, MTR_DMEM = 2'b01, MTR_PC4 = 2'b10;
   localparam logic [1:0] PSIZE_SCALAR = 2'b11;

   localparam logic [6:0] OPC_LUI   = 7'b0110111, OPC_AUIPC = 7'b0010111,
                          OPC_JAL   = 7'b1101111, OPC_JALR  = 7'b1100111,
                          OPC_BR    = 7'b1100011, OPC_LOAD  = 7'b0000011,
                          OPC_STORE = 7'b0100011, OPC_FUNC1 = 7'b0010011,
                          OPC_FUNC2 = 7'b0110011, OPC_FENCE = 7'b0001111,
                          OPC_SYS   = 7'b1110011, OPC_PACK  = 7'b0001011;

   localparam logic [4:0] ALU_IADD = 5'd0,  ALU_ISUB = 5'd1,  ALU_ISLL = 5'd2,
                          ALU_ISLT = 5'd3,  ALU_ISLTU = 5'd4, ALU_IXOR = 5'd5,
                          ALU_ISRL = 5'd6,  ALU_ISRA = 5'd7,  ALU_IOR  = 5'd8,
                          ALU_IAND = 5'd9,  ALU_PADD = 5'd10, ALU_PSUB = 5'd11,
                          ALU_BR   = 5'd16;

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_e;

   typedef struct packed {
      logic [2:0] ft;
      logic [1:0] memtoreg;
      logic       regwrite;
      logic       branch;
      logic [1:0] memwrite;
      logic [1:0] memread;
      logic       alusrc;
      logic [4:0] aluop;
      logic       dmse;
      logic       aluorshift;
      logic       rs1_pc;
      logic       rs1_z;
      logic [1:0] pack_size;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{ft: FT_R, memtoreg: MTR_ALU, regwrite: 1'b0,
                                    branch: 1'b0, memwrite: MEM_NONE, memread: MEM_NONE,
                                    alusrc: 1'b0, aluop: ALU_IADD, dmse: 1'b0,
                                    aluorshift: 1'b0, rs1_pc: 1'b0, rs1_z: 1'b0,
                                    pack_size: PSIZE_SCALAR, illegal: 1'b0};

   function automatic ctrl_t strip_enables(input ctrl_t c);
      ctrl_t r;
      r          = c;
      r.regwrite = 1'b0;
      r.branch   = 1'b0;
      r.memwrite = MEM_NONE;
      r.memread  = MEM_NONE;
      return r;
   endfunction

   // A bubble carries no side effects and must not trap either.
   function automatic ctrl_t bubble_ctrl(input ctrl_t c);
      ctrl_t r;
      r         = strip_enables(c);
      r.illegal = 1'b0;
      return r;
   endfunction

   function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
      logic [4:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_ISUB : ALU_IADD;
         3'b001:  op = ALU_ISLL;
         3'b010:  op = ALU_ISLT;
         3'b011:  op = ALU_ISLTU;
         3'b100:  op = ALU_IXOR;
         3'b101:  op = alt ? ALU_ISRA : ALU_ISRL;
         3'b110:  op = ALU_IOR;
         default: op = ALU_IAND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_ex_stage_p_if.sv
// ID/EX boundary bus: valid/ready handshake plus all decoded fields.
interface id_ex_stage_p_if #(parameter int XLEN = 32);
   logic            ex_valid;
   logic            ex_ready;
   logic [2:0]      ft_ex;
   logic [1:0]      memtoreg_ex;
   logic            regwrite_ex;
   logic            branch_ex;
   logic [1:0]      memwrite_ex;
   logic [1:0]      memread_ex;
   logic            alusrc_ex;
   logic [4:0]      aluop_ex;
   logic            dmse_ex;
   logic            aluorshift_ex;
   logic            rs1_pc_ex;
   logic            rs1_z_ex;
   logic [4:0]      rs1_ex;
   logic [4:0]      rs2_ex;
   logic [4:0]      rd_ex;
   logic [XLEN-1:0] imm_ex;
   logic [1:0]      pack_size_ex;
   logic [XLEN-1:0] pc_ex;
   logic            illegal_ex;

   modport master (output ex_valid, ft_ex, memtoreg_ex, regwrite_ex, branch_ex, memwrite_ex,
                          memread_ex, alusrc_ex, aluop_ex, dmse_ex, aluorshift_ex, rs1_pc_ex,
                          rs1_z_ex, rs1_ex, rs2_ex, rd_ex, imm_ex, pack_size_ex, pc_ex, illegal_ex,
                   input  ex_ready);

   modport slave  (input  ex_valid, ft_ex, memtoreg_ex, regwrite_ex, branch_ex, memwrite_ex,
                          memread_ex, alusrc_ex, aluop_ex, dmse_ex, aluorshift_ex, rs1_pc_ex,
                          rs1_z_ex, rs1_ex, rs2_ex, rd_ex, imm_ex, pack_size_ex, pc_ex, illegal_ex,
                   output ex_ready);
endinterface

// File: rtl/id_ex_stage_p_decode.sv
// Combinational RV32I + packed add/sub decoder: IR -> control bundle, immediate, illegal flag.
module id_ex_stage_p_decode
   import id_ex_stage_p_pkg::*;
#(
   parameter bit PACK_EN = 1'b1
) (
   input  logic [31:0] ir,
   output ctrl_t       ctrl,
   output logic [31:0] imm,
   output logic        rs1_used,
   output logic        rs2_used
);

   logic [6:0]  opc_s;
   logic [2:0]  f3_s;
   logic [6:0]  f7_s;
   logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
   ctrl_t       ctrl_s;

   assign opc_s   = ir[6:0];
   assign f3_s    = ir[14:12];
   assign f7_s    = ir[31:25];
   assign imm_i_s = {{20{ir[31]}}, ir[31:20]};
   assign imm_s_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b_s = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u_s = {ir[31:12], 12'h000};
   assign imm_j_s = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   // Opcode/funct decode into the raw control bundle.
   always_comb begin
      ctrl_s    = CTRL_RESET;
      ctrl_s.ft = FT_I;
      imm       = 32'h0000_0000;
      rs1_used  = 1'b1;
      rs2_used  = 1'b0;
      case (opc_s)
         OPC_LUI, OPC_AUIPC: begin
            ctrl_s.ft       = FT_U;
            ctrl_s.regwrite = 1'b1;
            ctrl_s.alusrc   = 1'b1;
            ctrl_s.rs1_z    = (opc_s == OPC_LUI);
            ctrl_s.rs1_pc   = (opc_s == OPC_AUIPC);
            imm             = imm_u_s;
            rs1_used        = 1'b0;
         end
         OPC_JAL, OPC_JALR: begin
            ctrl_s.ft       = (opc_s == OPC_JAL) ? FT_J : FT_I;
            ctrl_s.regwrite = 1'b1;
            ctrl_s.branch   = 1'b1;
            ctrl_s.memtoreg = MTR_PC4;
            ctrl_s.alusrc   = 1'b1;
            ctrl_s.rs1_pc   = (opc_s == OPC_JAL);
            ctrl_s.illegal  = (opc_s == OPC_JALR) && (f3_s != 3'b000);
            imm             = (opc_s == OPC_JAL) ? imm_j_s : imm_i_s;
            rs1_used        = (opc_s == OPC_JALR);
         end
         OPC_BR: begin
            ctrl_s.ft      = FT_B;
            ctrl_s.branch  = 1'b1;
            ctrl_s.aluop   = ALU_BR | {2'b00, f3_s};
            ctrl_s.illegal = (f3_s[2:1] == 2'b01);
            imm            = imm_b_s;
            rs2_used       = 1'b1;
         end
         OPC_LOAD: begin
            ctrl_s.regwrite = 1'b1;
            ctrl_s.memtoreg = MTR_DMEM;
            ctrl_s.memread  = f3_s[1:0] + 2'b01;
            ctrl_s.dmse     = ~f3_s[2];
            ctrl_s.alusrc   = 1'b1;
            ctrl_s.illegal  = (f3_s[1:0] == 2'b11) || (f3_s == 3'b110);
            imm             = imm_i_s;
         end
         OPC_STORE: begin
            ctrl_s.ft       = FT_S;
            ctrl_s.memwrite = f3_s[1:0] + 2'b01;
            ctrl_s.alusrc   = 1'b1;
            ctrl_s.illegal  = f3_s[2] || (f3_s[1:0] == 2'b11);
            imm             = imm_s_s;
            rs2_used        = 1'b1;
         end
         OPC_FUNC1: begin
            ctrl_s.regwrite   = 1'b1;
            ctrl_s.alusrc     = 1'b1;
            ctrl_s.aluop      = alu_of(f3_s, (f3_s == 3'b101) && ir[30]);
            ctrl_s.aluorshift = (f3_s[1:0] == 2'b01);
            ctrl_s.illegal    = ((f3_s == 3'b001) && (f7_s != 7'b0000000)) ||
                                ((f3_s == 3'b101) && (f7_s != 7'b0000000) && (f7_s != 7'b0100000));
            imm               = imm_i_s;
         end
         OPC_FUNC2: begin
            ctrl_s.ft         = FT_R;
            ctrl_s.regwrite   = 1'b1;
            ctrl_s.aluop      = alu_of(f3_s, ir[30]);
            ctrl_s.aluorshift = (f3_s[1:0] == 2'b01);
            ctrl_s.illegal    = !((f7_s == 7'b0000000) ||
                                  ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))));
            rs2_used          = 1'b1;
         end
         OPC_FENCE, OPC_SYS: begin
            ctrl_s.ft = FT_I;
         end
         OPC_PACK: begin
            ctrl_s.ft = FT_P;
            rs2_used  = 1'b1;
            if (PACK_EN) begin
               ctrl_s.regwrite  = 1'b1;
               ctrl_s.aluop     = (f3_s == 3'b000) ? ALU_PADD : ALU_PSUB;
               ctrl_s.pack_size = ir[26:25];
               ctrl_s.illegal   = (f3_s[2:1] != 2'b00) || (f7_s[6:2] != 5'b00000);
            end else begin
               ctrl_s.illegal = 1'b1;
            end
         end
         default: begin
            ctrl_s.illegal = 1'b1;
         end
      endcase
   end

   assign ctrl = ctrl_s.illegal ? strip_enables(ctrl_s) : ctrl_s;

endmodule

// File: rtl/id_ex_stage_p.sv
// Decode stage with elastic ID/EX register, load-use interlock and flush.
module id_ex_stage_p
   import id_ex_stage_p_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit PACK_EN    = 1'b1,
   parameter bit LOADUSE_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     ir_if,
   input  logic [XLEN-1:0] pc_if,
   input  logic            flush,
   id_ex_stage_p_if.master ex
);

   ctrl_t           dec_ctrl_s;
   logic [31:0]     dec_imm_s;
   logic            rs1_used_s, rs2_used_s;
   logic            hazard_s, advance_s;
   state_e          state_r, state_nx_s;
   logic            valid_r;
   ctrl_t           ctrl_r;
   logic [4:0]      rs1_r, rs2_r, rd_r;
   logic [XLEN-1:0] imm_r, pc_r;

   id_ex_stage_p_decode #(.PACK_EN(PACK_EN)) u_decode (
      .ir       (ir_if),
      .ctrl     (dec_ctrl_s),
      .imm      (dec_imm_s),
      .rs1_used (rs1_used_s),
      .rs2_used (rs2_used_s)
   );

   // Load in EX whose destination feeds a source of the incoming instruction.
   always_comb begin
      hazard_s = 1'b0;
      if (LOADUSE_EN && valid_r && (ctrl_r.memread != MEM_NONE) && (rd_r != 5'd0)) begin
         hazard_s = (rs1_used_s && (ir_if[19:15] == rd_r)) ||
                    (rs2_used_s && (ir_if[24:20] == rd_r));
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign advance_s = !valid_r || ex.ex_ready;
   assign if_ready  = advance_s && !hazard_s && !flush;

   // Interlock FSM next state.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (!flush && hazard_s && ex.ex_ready && if_valid) begin
               state_nx_s = ST_STALL;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_STALL: state_nx_s = ST_RUN;
         default:  state_nx_s = ST_RUN;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // ID/EX pipeline register: flush beats load, bubble on stall, hold while EX is busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         ctrl_r  <= CTRL_RESET;
         rs1_r   <= 5'd0;
         rs2_r   <= 5'd0;
         rd_r    <= 5'd0;
         imm_r   <= '0;
         pc_r    <= '0;
      end else if (flush) begin
         valid_r <= 1'b0;
         ctrl_r  <= bubble_ctrl(ctrl_r);
      end else if (advance_s) begin
         if (if_valid && !hazard_s) begin
            valid_r <= 1'b1;
            ctrl_r  <= dec_ctrl_s;
            rs1_r   <= ir_if[19:15];
            rs2_r   <= ir_if[24:20];
            rd_r    <= ir_if[11:7];
            imm_r   <= XLEN'($signed(dec_imm_s));
            pc_r    <= pc_if;
         end else begin
            valid_r <= 1'b0;
            ctrl_r  <= bubble_ctrl(ctrl_r);
         end
      end else begin
         valid_r <= valid_r;
      end
   end

   assign ex.ex_valid      = valid_r;
   assign ex.ft_ex         = ctrl_r.ft;
   assign ex.memtoreg_ex   = ctrl_r.memtoreg;
   assign ex.regwrite_ex   = ctrl_r.regwrite;
   assign ex.branch_ex     = ctrl_r.branch;
   assign ex.memwrite_ex   = ctrl_r.memwrite;
   assign ex.memread_ex    = ctrl_r.memread;
   assign ex.alusrc_ex     = ctrl_r.alusrc;
   assign ex.aluop_ex      = ctrl_r.aluop;
   assign ex.dmse_ex       = ctrl_r.dmse;
   assign ex.aluorshift_ex = ctrl_r.aluorshift;
   assign ex.rs1_pc_ex     = ctrl_r.rs1_pc;
   assign ex.rs1_z_ex      = ctrl_r.rs1_z;
   assign ex.pack_size_ex  = ctrl_r.pack_size;
   assign ex.illegal_ex    = ctrl_r.illegal;
   assign ex.rs1_ex        = rs1_r;
   assign ex.rs2_ex        = rs2_r;
   assign ex.rd_ex         = rd_r;
   assign ex.imm_ex        = imm_r;
   assign ex.pc_ex         = pc_r;

endmodule
